// File: rtl/border_expander_param.sv
// Border expander for the DWT 9/7 lifting core.
// Takes one line of {odd, even} sample pairs and re-emits it with ExtPairs
// extension pairs in front and behind. Symmetric, replicate or zero-pad
// extension is chosen per line. Short lines and unexpected sof are flagged
// on err_o.
module border_expander_param #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned ExtPairs  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [1:0]             mode_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [2*DataWidth-1:0] s_data_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o,
    output logic                   err_o
);

    localparam int unsigned PairW = 2 * DataWidth;
    localparam int unsigned CntW  = $clog2(ExtPairs + 2);

    localparam logic [CntW-1:0] CntLast    = CntW'(ExtPairs);
    localparam logic [CntW-1:0] CntExtLast = CntW'(ExtPairs - 1);
    localparam logic [1:0]      ModeRepl   = 2'd1;
    localparam logic [1:0]      ModeZero   = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        HEAD,
        STREAM,
        DRAIN,
        TAIL
    } state_t;

    state_t          state;
    logic [CntW-1:0] cnt;
    logic [1:0]      mode_q;
    logic            eol_seen;
    logic            live;

    // pair_buf[0] is the oldest pair, pair_buf[ExtPairs] the newest.
    logic [PairW-1:0] pair_buf [0:ExtPairs];

    logic             out_free;
    logic             accept;
    logic             push;
    logic [PairW-1:0] ext_beat;
    logic [PairW-1:0] drain_beat;

    // Input readiness: only IDLE, FILL and (with output space) STREAM take beats.
    always_comb begin
        out_free  = !m_valid_o || m_ready_i;
        s_ready_o = 1'b0;
        unique case (state)
            IDLE, FILL: s_ready_o = live;
            STREAM:     s_ready_o = live && out_free;
            default:    s_ready_o = 1'b0;
        endcase
        accept = s_valid_i && s_ready_o;
        push   = accept && (s_sof_i || state == FILL || state == STREAM);
    end

    // Extension beat for the current head/tail index held in cnt.
    // Head and tail use the same symmetric index pattern because the
    // buffer holds pairs 0..E during HEAD and pairs P-1-E..P-1 during TAIL.
    always_comb begin
        ext_beat = '0;
        if (mode_q == ModeRepl) begin
            if (state == TAIL) begin
                ext_beat = {2{pair_buf[ExtPairs][PairW-1:DataWidth]}};
            end else begin
                ext_beat = {2{pair_buf[0][DataWidth-1:0]}};
            end
        end else if (mode_q != ModeZero) begin
            for (int unsigned i = 0; i < ExtPairs; i++) begin
                if (cnt == CntW'(i)) begin
                    ext_beat = {pair_buf[ExtPairs-1-i][PairW-1:DataWidth],
                                pair_buf[ExtPairs-i][DataWidth-1:0]};
                end
            end
        end
    end

    // Pair selected from the buffer while draining the line end.
    always_comb begin
        drain_beat = pair_buf[0];
        for (int unsigned i = 0; i <= ExtPairs; i++) begin
            if (cnt == CntW'(i)) begin
                drain_beat = pair_buf[i];
            end
        end
    end

    // Delay-line buffer: every accepted line pair shifts in at the newest end.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i <= ExtPairs; i++) begin
                pair_buf[i] <= '0;
            end
        end else if (push) begin
            for (int unsigned i = 0; i < ExtPairs; i++) begin
                pair_buf[i] <= pair_buf[i+1];
            end
            pair_buf[ExtPairs] <= s_data_i;
        end
    end

    // Line FSM with registered output beat and error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_q    <= '0;
            eol_seen  <= 1'b0;
            live      <= 1'b0;
            err_o     <= 1'b0;
            m_valid_o <= 1'b0;
            m_sof_o   <= 1'b0;
            m_eol_o   <= 1'b0;
            m_data_o  <= '0;
        end else begin
            live  <= 1'b1;
            err_o <= 1'b0;
            if (m_valid_o && m_ready_i) begin
                m_valid_o <= 1'b0;
            end

            if (accept && s_sof_i) begin
                // A sof outside IDLE abandons the line in progress; a sof that
                // also carries eol is a one-pair line and is rejected at once.
                err_o    <= (state != IDLE) || s_eol_i;
                mode_q   <= mode_i;
                cnt      <= CntW'(1);
                eol_seen <= 1'b0;
                state    <= s_eol_i ? IDLE : FILL;
            end else begin
                unique case (state)
                    IDLE: begin
                    end

                    FILL: begin
                        if (accept) begin
                            if (cnt == CntLast) begin
                                eol_seen <= s_eol_i;
                                cnt      <= '0;
                                state    <= HEAD;
                            end else if (s_eol_i) begin
                                err_o <= 1'b1;
                                state <= IDLE;
                            end else begin
                                cnt <= cnt + CntW'(1);
                            end
                        end
                    end

                    HEAD: begin
                        if (out_free) begin
                            m_valid_o <= 1'b1;
                            m_data_o  <= ext_beat;
                            m_sof_o   <= (cnt == '0);
                            m_eol_o   <= 1'b0;
                            if (cnt == CntExtLast) begin
                                cnt   <= '0;
                                state <= eol_seen ? DRAIN : STREAM;
                            end else begin
                                cnt <= cnt + CntW'(1);
                            end
                        end
                    end

                    STREAM: begin
                        if (accept) begin
                            m_valid_o <= 1'b1;
                            m_data_o  <= pair_buf[0];
                            m_sof_o   <= 1'b0;
                            m_eol_o   <= 1'b0;
                            if (s_eol_i) begin
                                cnt   <= '0;
                                state <= DRAIN;
                            end
                        end
                    end

                    DRAIN: begin
                        if (out_free) begin
                            m_valid_o <= 1'b1;
                            m_data_o  <= drain_beat;
                            m_sof_o   <= 1'b0;
                            m_eol_o   <= 1'b0;
                            if (cnt == CntLast) begin
                                cnt   <= '0;
                                state <= TAIL;
                            end else begin
                                cnt <= cnt + CntW'(1);
                            end
                        end
                    end

                    TAIL: begin
                        // cnt == E means the eol beat is loaded; leave only
                        // once it has actually transferred.
                        if (cnt == CntLast) begin
                            if (m_valid_o && m_ready_i) begin
                                cnt   <= '0;
                                state <= IDLE;
                            end
                        end else if (out_free) begin
                            m_valid_o <= 1'b1;
                            m_data_o  <= ext_beat;
                            m_sof_o   <= 1'b0;
                            m_eol_o   <= (cnt == CntExtLast);
                            cnt       <= cnt + CntW'(1);
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_border_expander_param.sv
// Self-checking bench for border_expander_param (E=2 and E=1 instances).
module tb_border_expander_param;

    typedef struct packed {
        logic        sof;
        logic        eol;
        logic [15:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        s_valid_e2, s_valid_e1, s_sof, s_eol;
    logic [15:0] s_data;
    logic        m_ready;

    logic        s_ready_e2, m_valid_e2, m_sof_e2, m_eol_e2, err_e2;
    logic [15:0] m_data_e2;
    logic        s_ready_e1, m_valid_e1, m_sof_e1, m_eol_e1, err_e1;
    logic [15:0] m_data_e1;

    int    errors    = 0;
    int    checks    = 0;
    int    ready_pct = 100;
    beat_t got_e2[$];
    beat_t got_e1[$];
    int    err_hi_e2 = 0;
    int    err_hi_e1 = 0;
    int    hold_viol = 0;
    logic  stall_e2  = 1'b0;
    logic  stall_e1  = 1'b0;
    beat_t held_e2, held_e1;

    always #5 clk = ~clk;

    border_expander_param #(.DataWidth(8), .ExtPairs(2)) dut_e2 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode),
        .s_valid_i(s_valid_e2), .s_ready_o(s_ready_e2), .s_sof_i(s_sof), .s_eol_i(s_eol),
        .s_data_i(s_data), .m_valid_o(m_valid_e2), .m_ready_i(m_ready), .m_sof_o(m_sof_e2),
        .m_eol_o(m_eol_e2), .m_data_o(m_data_e2), .err_o(err_e2)
    );

    border_expander_param #(.DataWidth(8), .ExtPairs(1)) dut_e1 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode),
        .s_valid_i(s_valid_e1), .s_ready_o(s_ready_e1), .s_sof_i(s_sof), .s_eol_i(s_eol),
        .s_data_i(s_data), .m_valid_o(m_valid_e1), .m_ready_i(m_ready), .m_sof_o(m_sof_e1),
        .m_eol_o(m_eol_e1), .m_data_o(m_data_e1), .err_o(err_e1)
    );

    // Output monitor: records transferred beats, error-high cycles, stall holds.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_e2 && (!m_valid_e2 || {m_sof_e2, m_eol_e2, m_data_e2} != held_e2))
                hold_viol <= hold_viol + 1;
            if (stall_e1 && (!m_valid_e1 || {m_sof_e1, m_eol_e1, m_data_e1} != held_e1))
                hold_viol <= hold_viol + 1;
            if (m_valid_e2 && m_ready) got_e2.push_back({m_sof_e2, m_eol_e2, m_data_e2});
            if (m_valid_e1 && m_ready) got_e1.push_back({m_sof_e1, m_eol_e1, m_data_e1});
            if (err_e2) err_hi_e2 <= err_hi_e2 + 1;
            if (err_e1) err_hi_e1 <= err_hi_e1 + 1;
            stall_e2 <= m_valid_e2 && !m_ready;
            stall_e1 <= m_valid_e1 && !m_ready;
            held_e2  <= {m_sof_e2, m_eol_e2, m_data_e2};
            held_e1  <= {m_sof_e1, m_eol_e1, m_data_e1};
        end else begin
            stall_e2 <= 1'b0;
            stall_e1 <= 1'b0;
        end
    end

    // Downstream backpressure generator.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(99) < ready_pct);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    // Reference: expected beats of one complete line from the extension rules.
    function automatic void model(input int x[$], input int md, input int e, output beat_t q[$]);
        int    n;
        int    p;
        beat_t b;
        n = x.size();
        p = n / 2;
        q = {};
        for (int k = 0; k < e; k++) begin
            b.sof = (k == 0);
            b.eol = 1'b0;
            case (md)
                1:       b.data = {8'(x[0]), 8'(x[0])};
                2:       b.data = 16'h0000;
                default: b.data = {8'(x[2*e-2*k-1]), 8'(x[2*e-2*k])};
            endcase
            q.push_back(b);
        end
        for (int i = 0; i < p; i++) begin
            b.sof  = 1'b0;
            b.eol  = 1'b0;
            b.data = {8'(x[2*i+1]), 8'(x[2*i])};
            q.push_back(b);
        end
        for (int j = 0; j < e; j++) begin
            b.sof = 1'b0;
            b.eol = (j == e - 1);
            case (md)
                1:       b.data = {8'(x[n-1]), 8'(x[n-1])};
                2:       b.data = 16'h0000;
                default: b.data = {8'(x[n-3-2*j]), 8'(x[n-2-2*j])};
            endcase
            q.push_back(b);
        end
    endfunction

    function automatic void mk_line(input int p, input bit ramp, output int x[$]);
        x = {};
        for (int i = 0; i < 2 * p; i++) x.push_back(ramp ? i : int'($urandom_range(255)));
    endfunction

    // Drive one beat to the chosen instance; entered and left at posedge+1.
    task automatic drive(input int e, input logic [15:0] d, input logic sof, input logic eol,
                         input logic [1:0] md, input int gap_pct);
        int n;
        if ($urandom_range(99) < gap_pct)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        s_data = d;
        s_sof  = sof;
        s_eol  = eol;
        mode   = md;
        if (e == 2) s_valid_e2 = 1'b1; else s_valid_e1 = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if ((e == 2) ? s_ready_e2 : s_ready_e1) break;
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: e=%0d beat still pending after %0d cycles, required accept", e, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid_e2 = 1'b0;
        s_valid_e1 = 1'b0;
    endtask

    // Send the first nbeats pairs of line x; mode is random except on sof.
    task automatic send_line(input int e, input int x[$], input logic [1:0] md, input int gap_pct,
                             input int nbeats);
        int p;
        p = x.size() / 2;
        for (int i = 0; i < nbeats; i++)
            drive(e, {8'(x[2*i+1]), 8'(x[2*i])}, i == 0, i == p - 1,
                  (i == 0) ? md : 2'($urandom_range(3)), gap_pct);
    endtask

    task automatic wait_out(input int e, input int n);
        for (int c = 0; c < 4000; c++) begin
            if (((e == 2) ? got_e2.size() : got_e1.size()) >= n) break;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        if (s_ready_e2 !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready_e2); end
        checks++;
        if (m_valid_e2 !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid_e2); end
        checks++;
        if ({m_sof_e2, m_eol_e2, err_e2} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {m_sof_e2, m_eol_e2, err_e2});
        end
        checks++;
        if (m_data_e2 !== 16'h0000) begin errors++; $display("FAIL reset_m_data: got %h want 0000", m_data_e2); end
        checks++;
        if ({s_ready_e1, m_valid_e1} !== 2'b00) begin
            errors++; $display("FAIL reset_e1: got %b want 00", {s_ready_e1, m_valid_e1});
        end
        checks++;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        if (s_ready_e2 !== 1'b1) begin errors++; $display("FAIL idle_s_ready: got %b want 1", s_ready_e2); end
        checks++;
    endtask

    task automatic test_symmetric;
        int    x[$];
        beat_t exp[$];
        beat_t g;
        int    base, ebase;
        ready_pct = 100;
        mk_line(8, 1'b1, x);
        model(x, 0, 2, exp);
        base  = got_e2.size();
        ebase = err_hi_e2;
        send_line(2, x, 2'd0, 0, 8);
        wait_out(2, base + exp.size());
        if (got_e2.size() - base !== 12) begin
            errors++; $display("FAIL sym_count: got %0d want 12", got_e2.size() - base);
        end
        checks++;
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got_e2.size()) g = got_e2[base+i]; else g = 'x;
            if (g !== exp[i]) begin errors++; $display("FAIL sym_beat%0d: got %h want %h", i, g, exp[i]); end
            checks++;
        end
        if (got_e2.size() > base + 11) begin
            if (got_e2[base] !== {1'b1, 1'b0, 16'h0304}) begin
                errors++; $display("FAIL sym_first: got %h want %h", got_e2[base], {1'b1, 1'b0, 16'h0304});
            end
            checks++;
            if (got_e2[base+11] !== {1'b0, 1'b1, 16'h0B0C}) begin
                errors++; $display("FAIL sym_last: got %h want %h", got_e2[base+11], {1'b0, 1'b1, 16'h0B0C});
            end
            checks++;
        end
        if (err_hi_e2 !== ebase) begin errors++; $display("FAIL sym_err: got %0d want %0d", err_hi_e2, ebase); end
        checks++;
    endtask

    task automatic test_modes;
        int    x[$];
        beat_t exp[$];
        beat_t g;
        int    base;
        int    md;
        ready_pct = 100;
        for (int t = 0; t < 4; t++) begin
            md = (t == 0) ? 1 : (t == 1) ? 2 : (t == 2) ? 3 : 1;
            mk_line((t < 2) ? 8 : 3 + t, t < 2, x);
            model(x, md, 2, exp);
            base = got_e2.size();
            send_line(2, x, 2'(md), 0, x.size() / 2);
            wait_out(2, base + exp.size());
            if (got_e2.size() - base !== exp.size()) begin
                errors++; $display("FAIL mode%0d_count: got %0d want %0d", md, got_e2.size() - base, exp.size());
            end
            checks++;
            for (int i = 0; i < exp.size(); i++) begin
                if (base + i < got_e2.size()) g = got_e2[base+i]; else g = 'x;
                if (g !== exp[i]) begin
                    errors++; $display("FAIL mode%0d_beat%0d: got %h want %h", md, i, g, exp[i]);
                end
                checks++;
            end
        end
    endtask

    task automatic test_back_to_back;
        int    x[$];
        beat_t one[$];
        beat_t exp[$];
        beat_t g;
        int    base, hbase;
        ready_pct = 50;
        base  = got_e2.size();
        hbase = hold_viol;
        exp   = {};
        for (int l = 0; l < 3; l++) begin
            mk_line($urandom_range(3, 10), 1'b0, x);
            model(x, (l == 1) ? 3 : 0, 2, one);
            exp = {exp, one};
            send_line(2, x, (l == 1) ? 2'd3 : 2'd0, 30, x.size() / 2);
        end
        wait_out(2, base + exp.size());
        if (got_e2.size() - base !== exp.size()) begin
            errors++; $display("FAIL b2b_count: got %0d want %0d", got_e2.size() - base, exp.size());
        end
        checks++;
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got_e2.size()) g = got_e2[base+i]; else g = 'x;
            if (g !== exp[i]) begin errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, g, exp[i]); end
            checks++;
        end
        if (hold_viol !== hbase) begin errors++; $display("FAIL stall_hold: got %0d want %0d", hold_viol, hbase); end
        checks++;
        ready_pct = 100;
    endtask

    task automatic test_short_line;
        int    x[$];
        beat_t exp[$];
        beat_t g;
        int    base, ebase;
        ready_pct = 100;
        base  = got_e2.size();
        ebase = err_hi_e2;
        mk_line(2, 1'b0, x);
        send_line(2, x, 2'd0, 0, 2);
        repeat (8) @(posedge clk);
        #1;
        if (got_e2.size() !== base) begin errors++; $display("FAIL short_out: got %0d want %0d", got_e2.size(), base); end
        checks++;
        if (err_hi_e2 - ebase !== 1) begin errors++; $display("FAIL short_err: got %0d want 1", err_hi_e2 - ebase); end
        checks++;
        mk_line(1, 1'b0, x);
        send_line(2, x, 2'd0, 0, 1);
        repeat (8) @(posedge clk);
        #1;
        if (err_hi_e2 - ebase !== 2) begin errors++; $display("FAIL sofeol_err: got %0d want 2", err_hi_e2 - ebase); end
        checks++;
        mk_line(8, 1'b1, x);
        model(x, 0, 2, exp);
        send_line(2, x, 2'd0, 0, 8);
        wait_out(2, base + exp.size());
        if (got_e2.size() - base !== exp.size()) begin
            errors++; $display("FAIL short_next_count: got %0d want %0d", got_e2.size() - base, exp.size());
        end
        checks++;
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got_e2.size()) g = got_e2[base+i]; else g = 'x;
            if (g !== exp[i]) begin errors++; $display("FAIL short_next_beat%0d: got %h want %h", i, g, exp[i]); end
            checks++;
        end
    endtask

    task automatic test_sof_restart;
        int    xa[$], xb[$];
        beat_t ea[$], eb[$], exp[$];
        beat_t g;
        int    base, ebase;
        ready_pct = 50;
        mk_line(8, 1'b1, xa);
        mk_line(8, 1'b0, xb);
        model(xa, 0, 2, ea);
        model(xb, 0, 2, eb);
        // 5 pairs accepted: 3 fill the buffer, 2 push pairs 0 and 1 out after the 2 head beats.
        exp = {ea[0:3], eb};
        base  = got_e2.size();
        ebase = err_hi_e2;
        send_line(2, xa, 2'd0, 0, 5);
        send_line(2, xb, 2'd0, 20, 8);
        wait_out(2, base + exp.size());
        if (got_e2.size() - base !== exp.size()) begin
            errors++; $display("FAIL restart_count: got %0d want %0d", got_e2.size() - base, exp.size());
        end
        checks++;
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got_e2.size()) g = got_e2[base+i]; else g = 'x;
            if (g !== exp[i]) begin errors++; $display("FAIL restart_beat%0d: got %h want %h", i, g, exp[i]); end
            checks++;
        end
        if (err_hi_e2 - ebase !== 1) begin errors++; $display("FAIL restart_err: got %0d want 1", err_hi_e2 - ebase); end
        checks++;
        ready_pct = 100;
    endtask

    task automatic test_reset_mid;
        int    x[$];
        beat_t exp[$];
        beat_t g;
        int    base;
        ready_pct = 100;
        mk_line(8, 1'b1, x);
        send_line(2, x, 2'd0, 0, 6);
        if (m_valid_e2 !== 1'b1) begin errors++; $display("FAIL mid_stream_valid: got %b want 1", m_valid_e2); end
        checks++;
        #2 rst_n = 1'b0;
        #1;
        if ({m_valid_e2, m_sof_e2, m_eol_e2, s_ready_e2} !== 4'b0000) begin
            errors++; $display("FAIL async_reset_ctl: got %b want 0000", {m_valid_e2, m_sof_e2, m_eol_e2, s_ready_e2});
        end
        checks++;
        if (m_data_e2 !== 16'h0000) begin errors++; $display("FAIL async_reset_data: got %h want 0000", m_data_e2); end
        checks++;
        @(posedge clk);
        #3 rst_n = 1'b1;
        base = got_e2.size();
        repeat (20) @(posedge clk);
        #1;
        if (got_e2.size() !== base) begin
            errors++; $display("FAIL residual: got %0d beats want 0", got_e2.size() - base);
        end
        checks++;
        mk_line(6, 1'b0, x);
        model(x, 1, 2, exp);
        send_line(2, x, 2'd1, 0, 6);
        wait_out(2, base + exp.size());
        if (got_e2.size() - base !== exp.size()) begin
            errors++; $display("FAIL post_reset_count: got %0d want %0d", got_e2.size() - base, exp.size());
        end
        checks++;
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got_e2.size()) g = got_e2[base+i]; else g = 'x;
            if (g !== exp[i]) begin errors++; $display("FAIL post_reset_beat%0d: got %h want %h", i, g, exp[i]); end
            checks++;
        end
    endtask

    task automatic test_e1;
        int    x[$];
        beat_t exp[$];
        beat_t g;
        int    base;
        for (int t = 0; t < 2; t++) begin
            ready_pct = (t == 0) ? 100 : 50;
            mk_line((t == 0) ? 4 : 7, t == 0, x);
            model(x, (t == 0) ? 0 : 1, 1, exp);
            base = got_e1.size();
            send_line(1, x, (t == 0) ? 2'd0 : 2'd1, (t == 0) ? 0 : 25, x.size() / 2);
            wait_out(1, base + exp.size());
            if (got_e1.size() - base !== exp.size()) begin
                errors++; $display("FAIL e1_count%0d: got %0d want %0d", t, got_e1.size() - base, exp.size());
            end
            checks++;
            for (int i = 0; i < exp.size(); i++) begin
                if (base + i < got_e1.size()) g = got_e1[base+i]; else g = 'x;
                if (g !== exp[i]) begin errors++; $display("FAIL e1_line%0d_beat%0d: got %h want %h", t, i, g, exp[i]); end
                checks++;
            end
            if (t == 0 && got_e1.size() >= base + 6) begin
                if (got_e1[base] !== {1'b1, 1'b0, 16'h0102}) begin
                    errors++; $display("FAIL e1_first: got %h want %h", got_e1[base], {1'b1, 1'b0, 16'h0102});
                end
                checks++;
                if (got_e1[base+5] !== {1'b0, 1'b1, 16'h0506}) begin
                    errors++; $display("FAIL e1_last: got %h want %h", got_e1[base+5], {1'b0, 1'b1, 16'h0506});
                end
                checks++;
            end
        end
        ready_pct = 100;
    endtask

    initial begin
        rst_n      = 1'b0;
        mode       = 2'd0;
        s_valid_e2 = 1'b0;
        s_valid_e1 = 1'b0;
        s_sof      = 1'b0;
        s_eol      = 1'b0;
        s_data     = '0;
        test_reset();
        test_symmetric();
        test_modes();
        test_back_to_back();
        test_short_line();
        test_sof_restart();
        test_reset_mid();
        test_e1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/border_expander_param.md
Name: border_expander_param

Overview:
- Parametrised successor to the fixed 2-pair DWT 9/7 border expander.
- Sits in front of the dwt97 lifting core. It receives one line of even/odd sample pairs and emits the line with ExtPairs extension pairs prepended and appended.
- Extension mode is selectable per line: whole-sample symmetric, edge replicate, or zero pad.
- Adds short-line and protocol-error detection.

Parameters:
- DataWidth, 8, bits per sample; a beat carries 2 samples (low lane = even index, high lane = odd index).
- ExtPairs, 2, extension pairs per side, E >= 1; each side gets 2E samples.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mode_i  in  2  0 = symmetric, 1 = replicate, 2 = zero, 3 = symmetric; sampled on the accepted sof beat
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  input ready
- s_sof_i  in  1  first pair of the line
- s_eol_i  in  1  last pair of the line
- s_data_i  in  2*DataWidth  {odd, even}
- m_valid_o  out  1  output valid
- m_ready_i  in  1  output ready
- m_sof_o  out  1  first output beat of the line
- m_eol_o  out  1  last output beat of the line
- m_data_o  out  2*DataWidth  {odd, even}
- err_o  out  1  one-cycle pulse on short line or unexpected sof

Behaviour:
- Reset: asynchronous, active-low, on clk_i.
  - While rst_ni = 0: state = IDLE, m_valid_o = 0, m_sof_o = 0, m_eol_o = 0, m_data_o = 0, err_o = 0, s_ready_o = 0.
  - Reset mid-line discards everything; no partial output appears after release.
- Handshakes:
  - AXI-stream style; a beat transfers when valid && ready.
  - Registered output: m_data_o, m_sof_o and m_eol_o hold stable while m_valid_o && !m_ready_i.
  - s_ready_o depends on state and on output-register space, never combinationally on s_valid_i.
- Notation: line x[0..N-1], N = 2P samples, P pairs; required P >= E+1.
- Per accepted line, output is exactly P+2E beats: head[0..E-1], the P input pairs unchanged and in order, tail[0..E-1].
- Extension contents by mode:
  - Symmetric: head[k] = {x[2E-2k-1], x[2E-2k]}; tail[j] = {x[N-3-2j], x[N-2-2j]}.
  - Replicate: head[k] = {x[0], x[0]}; tail[j] = {x[N-1], x[N-1]}.
  - Zero: all extension beats are 0.
- Flags: m_sof_o only on head[0]; m_eol_o only on tail[E-1].
- FSM states:
  - IDLE: s_ready_o = 1. Beats without sof are dropped. A sof beat latches mode and stores pair 0 -> FILL.
  - FILL: accepts pairs into an (E+1)-deep buffer, no output. After pair E -> HEAD.
  - HEAD: s_ready_o = 0; emits the E head beats from the buffer -> STREAM.
  - STREAM: emits buffered pairs as a delay line of E+1 pairs; each accepted input pushes one pair out. On the accepted eol beat -> DRAIN.
  - DRAIN: s_ready_o = 0; emits the remaining E+1 buffered pairs. The buffer retains the last E+1 pairs for tail generation -> TAIL.
  - TAIL: emits E tail beats; on acceptance of tail[E-1] -> IDLE.
- Steady-state throughput is 1 pair/cycle with m_ready_i = 1. Stalls occur only in HEAD, DRAIN and TAIL.
- First output beat is valid 1 cycle after HEAD entry.
- Boundary conditions:
  - Short line (eol accepted in FILL with P <= E): nothing is emitted, err_o pulses for 1 cycle, state -> IDLE.
  - sof and eol on the same beat: treated as a short line.
  - sof accepted in FILL or STREAM: the current line is abandoned (already-emitted beats stand, no eol generated), err_o pulses, and the new sof beat starts a fresh FILL.
  - sof is ignored in HEAD, DRAIN and TAIL because s_ready_o = 0 there.
  - Back-to-back lines: a new sof is accepted in the cycle after tail[E-1] transfers.
- Counters: pair-index and extension counters are $clog2(E+2) bits wide; P itself is never counted.

Test Plan:
- E=2, symmetric, 8 pairs of samples 0..15, m_ready_i = 1 -> 12 beats: {3,4},{1,2},{1,0},{3,2},...,{15,14},{13,14},{11,12}; sof on beat 0, eol on beat 11.
- E=2, replicate, same input -> head {0,0},{0,0}; tail {15,15},{15,15}; middle unchanged. Zero mode -> head and tail beats all 0x0000.
- Random m_ready_i (50%) and random gaps in s_valid_i, 3 back-to-back symmetric lines -> identical beat sequences to the no-stall case, no drops or duplicates, data held under stall.
- E=2, 2-pair line (sof then eol) -> no output beats, err_o high for exactly 1 cycle; a following valid 8-pair line is output correctly.
- sof injected at pair 5 of a line -> err_o pulses, and the second line is output complete with correct head extension.
- rst_ni low for 1 cycle mid-STREAM -> outputs zero immediately (asynchronously); after release no residual beats appear and the next line is correct. Repeat with an E=1 instance: line 0..7 -> {1,2},{1,0},...,{7,6},{5,6}.
